// File: rtl/ysyx_22050854_divider_2_pkg.sv
// Shared types for the radix-2 restoring divider.
// State encodings and counter width.
package ysyx_22050854_divider_2_pkg;

  localparam int XLEN_D = 64;
  localparam int CNT_W  = $clog2(XLEN_D);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/ysyx_22050854_div_signfix.sv
// Combinational negate / sign-extend helper.
// Used for operand magnitudes and final result fix-up.
module ysyx_22050854_div_signfix #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] value,
  input  logic            negate,
  input  logic            sext,
  output logic [XLEN-1:0] result
);

  localparam int H = XLEN / 2;

  logic [XLEN-1:0] t;

  assign t = negate ? -value : value;

  assign result = sext ? {{H{t[H-1]}}, t[H-1:0]} : t;

endmodule

// File: rtl/ysyx_22050854_divider_2.sv
// Iterative radix-2 restoring divider for RV64M div/rem.
// One quotient bit per cycle; results held until next op.
module ysyx_22050854_divider_2
  import ysyx_22050854_divider_2_pkg::*;
#(
  parameter int XLEN = XLEN_D
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            div_valid,
  input  logic            divw,
  input  logic            div_signed,
  output logic            div_doing,
  output logic            div_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int H = XLEN / 2;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  a_sh, b_r, q_r, rem_r;
  logic             q_neg, r_neg, w_r;

  logic [XLEN-1:0]  a_sx, a_ext, b_ext;
  logic [XLEN-1:0]  a_abs, b_abs, q_fix, r_fix;
  logic             a_neg, b_neg;
  logic             div_zero, ovf, special;
  logic [XLEN:0]    r_shift, diff;
  logic             q_bit;

  assign a_ext = (divw && !div_signed)
               ? {{H{1'b0}}, dividend[H-1:0]}
               : a_sx;
  assign b_ext = divw
               ? {{H{div_signed & divisor[H-1]}},
                  divisor[H-1:0]}
               : divisor;

  assign a_neg = div_signed & a_ext[XLEN-1];
  assign b_neg = div_signed & b_ext[XLEN-1];

  assign div_zero = divw ? ~|divisor[H-1:0]
                         : ~|divisor;

  // most-negative / -1 at the operating width
  assign ovf = div_signed & (divw
    ? (dividend[H-1:0] == {1'b1, {(H-1){1'b0}}})
      && (&divisor[H-1:0])
    : (dividend == {1'b1, {(XLEN-1){1'b0}}})
      && (&divisor));

  assign special = div_zero | ovf;

  ysyx_22050854_div_signfix #(.XLEN(XLEN)) u_a_sx (
    .value  (dividend),
    .negate (1'b0),
    .sext   (divw),
    .result (a_sx)
  );

  ysyx_22050854_div_signfix #(.XLEN(XLEN)) u_a_abs (
    .value  (a_ext),
    .negate (a_neg),
    .sext   (1'b0),
    .result (a_abs)
  );

  ysyx_22050854_div_signfix #(.XLEN(XLEN)) u_b_abs (
    .value  (b_ext),
    .negate (b_neg),
    .sext   (1'b0),
    .result (b_abs)
  );

  ysyx_22050854_div_signfix #(.XLEN(XLEN)) u_q_fix (
    .value  (q_r),
    .negate (q_neg),
    .sext   (w_r),
    .result (q_fix)
  );

  ysyx_22050854_div_signfix #(.XLEN(XLEN)) u_r_fix (
    .value  (rem_r),
    .negate (r_neg),
    .sext   (w_r),
    .result (r_fix)
  );

  // borrow out of the trial subtract means R < |divisor|
  assign r_shift = {rem_r, a_sh[XLEN-1]};
  assign diff    = r_shift - {1'b0, b_r};
  assign q_bit   = ~diff[XLEN];

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    div_ready = 1'b0;
    div_doing = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        div_ready = 1'b1;
        if (div_valid) begin
          state_nxt = special ? DONE : CALC;
        end
      end
      CALC: begin
        div_doing = 1'b1;
        if (cnt == '0) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        div_doing = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      a_sh      <= '0;
      b_r       <= '0;
      q_r       <= '0;
      rem_r     <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      w_r       <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (div_valid) begin
            w_r   <= divw;
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
            b_r   <= b_abs;
            a_sh  <= divw
                   ? {a_abs[H-1:0], {H{1'b0}}}
                   : a_abs;
            q_r   <= '0;
            rem_r <= '0;
            cnt   <= divw ? CNT_W'(H - 1)
                          : CNT_W'(XLEN - 1);
            if (special) begin
              quotient  <= div_zero ? '1 : a_sx;
              remainder <= div_zero ? a_sx : '0;
            end
          end
        end
        CALC: begin
          a_sh  <= a_sh << 1;
          q_r   <= {q_r[XLEN-2:0], q_bit};
          rem_r <= q_bit ? diff[XLEN-1:0]
                         : r_shift[XLEN-1:0];
          cnt   <= cnt - 1'b1;
        end
        FIX: begin
          quotient  <= q_fix;
          remainder <= r_fix;
        end
        DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050854_divider_2.sv
// Scoreboard bench for the restoring divider.
// Model results queued at issue, compared on out_valid.
module tb_ysyx_22050854_divider_2;

  logic        clock;
  logic        reset;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        div_valid;
  logic        divw;
  logic        div_signed;
  logic        div_doing;
  logic        div_ready;
  logic        out_valid;
  logic [63:0] quotient;
  logic [63:0] remainder;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  ysyx_22050854_divider_2 #(.XLEN(64)) dut (
    .clock      (clock),
    .reset      (reset),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_valid  (div_valid),
    .divw       (divw),
    .div_signed (div_signed),
    .div_doing  (div_doing),
    .div_ready  (div_ready),
    .out_valid  (out_valid),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic void model(input  logic [63:0] a,
                                input  logic [63:0] b,
                                input  logic w,
                                input  logic s,
                                output logic [63:0] q,
                                output logic [63:0] r,
                                output int lat);
    logic [31:0] a32, b32, q32, r32;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      lat = 34;
      if (b32 == 32'd0) begin
        q = '1; r = sx32(a32); lat = 1;
      end else if (s && a32 == 32'h8000_0000
                   && b32 == 32'hFFFF_FFFF) begin
        q = sx32(a32); r = '0; lat = 1;
      end else begin
        if (s) begin
          q32 = $signed(a32) / $signed(b32);
          r32 = $signed(a32) % $signed(b32);
        end else begin
          q32 = a32 / b32;
          r32 = a32 % b32;
        end
        q = sx32(q32); r = sx32(r32);
      end
    end else begin
      lat = 66;
      if (b == 64'd0) begin
        q = '1; r = a; lat = 1;
      end else if (s && a == 64'h8000_0000_0000_0000
                   && b == '1) begin
        q = a; r = '0; lat = 1;
      end else if (s) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  always @(negedge clock) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("quotient", quotient, mon_e.q);
        check("remainder", remainder, mon_e.r);
        check("latency_cycle", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  task automatic issue(input logic [63:0] a,
                       input logic [63:0] b,
                       input logic w,
                       input logic s,
                       input logic [63:0] eq,
                       input logic [63:0] er,
                       input int lat,
                       input bit push);
    @(negedge clock);
    check("ready_at_issue", 64'(div_ready), 64'd1);
    dividend   = a;
    divisor    = b;
    divw       = w;
    div_signed = s;
    div_valid  = 1'b1;
    if (push) sb.push_back('{eq, er, cyc + lat});
    @(posedge clock);
    #1;
    div_valid  = 1'b0;
    dividend   = {$urandom, $urandom};
    divisor    = {$urandom, $urandom};
    divw       = 1'($urandom);
    div_signed = 1'($urandom);
  endtask

  task automatic issue_m(input logic [63:0] a,
                         input logic [63:0] b,
                         input logic w,
                         input logic s);
    logic [63:0] q, r;
    int lat;
    model(a, b, w, s, q, r, lat);
    issue(a, b, w, s, q, r, lat, 1'b1);
  endtask

  task automatic wait_done();
    int bad;
    bit seen;
    bad  = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      if (!(div_doing && !div_ready)) bad++;
    end
    check("done_timeout", 64'(seen), 64'd1);
    if (seen) begin
      check("done_flags",
            {62'd0, div_ready, div_doing}, 64'd0);
      check("busy_flags", 64'(bad), 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] a, b;
    logic w, s;
    int sel;

    reset      = 1'b1;
    div_valid  = 1'b0;
    dividend   = '0;
    divisor    = '0;
    divw       = 1'b0;
    div_signed = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_ready", 64'(div_ready), 64'd1);
    check("rst_doing", 64'(div_doing), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_quotient", quotient, 64'd0);
    check("rst_remainder", remainder, 64'd0);
    reset = 1'b0;

    issue(64'd100, 64'd7, 1'b0, 1'b0,
          64'd14, 64'd2, 66, 1'b1);
    wait_done();

    issue(-64'sd7, 64'd2, 1'b0, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFD,
          64'hFFFF_FFFF_FFFF_FFFF, 66, 1'b1);
    wait_done();

    issue(64'h0000_0000_FFFF_FFFE, 64'd1, 1'b1, 1'b0,
          64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 34, 1'b1);
    wait_done();

    issue(64'd5, 64'd0, 1'b0, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1, 1'b1);
    wait_done();

    issue(64'h0000_0000_8000_0000,
          64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1,
          64'hFFFF_FFFF_8000_0000, 64'd0, 1, 1'b1);
    wait_done();

    // request pulsed mid-calculation must be dropped
    issue(64'd1000, 64'd33, 1'b0, 1'b0,
          64'd30, 64'd10, 66, 1'b1);
    repeat (10) @(negedge clock);
    dividend  = 64'd9;
    divisor   = 64'd0;
    div_valid = 1'b1;
    @(posedge clock);
    #1;
    div_valid = 1'b0;
    wait_done();
    repeat (3) @(negedge clock);
    check("held_quotient", quotient, 64'd30);
    check("held_remainder", remainder, 64'd10);

    // reset in the middle of a 64-bit operation
    issue(64'd12345, 64'd6, 1'b0, 1'b0,
          64'd0, 64'd0, 66, 1'b0);
    repeat (20) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_ready", 64'(div_ready), 64'd1);
    check("mid_rst_doing", 64'(div_doing), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_quotient", quotient, 64'd0);
    check("mid_rst_remainder", remainder, 64'd0);
    reset = 1'b0;
    repeat (70) @(negedge clock);

    issue_m(64'd77, 64'd5, 1'b0, 1'b0);
    wait_done();

    for (int i = 0; i < 16; i++) begin
      w   = 1'($urandom);
      s   = 1'($urandom);
      a   = {$urandom, $urandom};
      sel = $urandom_range(0, 5);
      unique case (sel)
        0: b = '0;
        1: begin
          b = '1;
          a = w ? {32'($urandom), 32'h8000_0000}
                : 64'h8000_0000_0000_0000;
        end
        2: b = 64'($urandom_range(1, 100));
        3: b = {$urandom, $urandom} >> $urandom_range(0, 63);
        default: b = {$urandom, $urandom};
      endcase
      issue_m(a, b, w, s);
      wait_done();
    end

    repeat (5) @(negedge clock);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22050854_divider_2.md
Name: ysyx_22050854_divider_2

Overview:
Iterative radix-2 restoring divider. It is the responder on the ALU's divide handshake (div_valid / div_ready / div_doing / out_valid) and is pin-compatible with the existing shift divider in the EXE stage. It supports RV64M div, divu, rem, remu and the W forms with RISC-V special-case semantics. Quotient and remainder are registered and held until the next accepted request.

Parameters:
XLEN, 64, operand/result width; the W forms use the low XLEN/2 bits

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
dividend  input  XLEN  dividend (src1)
divisor  input  XLEN  divisor (src2)
div_valid  input  1  request strobe; sampled only when div_ready=1
divw  input  1  1: 32-bit operation on the low halves
div_signed  input  1  1: signed (div/rem), 0: unsigned
div_doing  output  1  high in CALC and FIX
div_ready  output  1  high only in IDLE
out_valid  output  1  one-cycle pulse; results valid
quotient  output  XLEN  quotient
remainder  output  XLEN  remainder

Behaviour:
- Single clock. Reset is synchronous and active-high.
- Reset: state=IDLE, div_ready=1, div_doing=0, out_valid=0, quotient=0, remainder=0, counter=0. Reset asserted during any state aborts the operation in the same edge.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - div_valid=1 → latch operands, divw, div_signed.
  - divisor==0 (low 32 bits when divw) → DONE with special result.
  - Signed overflow (dividend = most-negative, divisor = -1, at the operating width) → DONE with special result.
  - Otherwise → CALC with counter = N-1, where N=64 (divw=0) or N=32 (divw=1).
- Operand prep at accept:
  - divw=1: take the low 32 bits, sign- or zero-extended per div_signed.
  - Signed: use absolute values; record q_neg = sign(a) XOR sign(b) and r_neg = sign(a).
- CALC, one bit per cycle:
  - Partial remainder R (XLEN+1 bits) = {R, next dividend bit}.
  - If R >= |divisor|: subtract and shift in quotient bit 1, else shift in 0.
  - Counter decrements; at counter==0 → FIX.
- FIX (1 cycle): negate the quotient if q_neg, negate the remainder if r_neg (signed only). divw=1: sign-extend bit 31 of both results to XLEN, for signed and unsigned alike. Then → DONE.
- DONE (1 cycle): out_valid=1, then → IDLE. quotient and remainder are written on entry to DONE and held through IDLE until the next DONE.
- Special results:
  - Divide by zero: quotient = all ones (sign-extended 0xFFFFFFFF when divw), remainder = dividend (sign-extended low 32 bits when divw).
  - Overflow: quotient = dividend (sign-extended when divw), remainder = 0.
- Latency, for div_valid accepted in cycle T:
  - Normal: out_valid in cycle T+N+2 (T+66 for 64-bit, T+34 for W).
  - Special case: out_valid in T+1.
- div_valid outside IDLE is ignored. No queueing.
- Inputs are not required to be stable after acceptance.
- out_valid never coincides with div_ready=1. A new request may be accepted in the cycle after DONE.

Decomposition:
- Shared package/header: state encodings (IDLE=0, CALC=1, FIX=2, DONE=3) and the counter width (clog2(XLEN)).
- Optional sub-module ysyx_22050854_div_signfix: combinational abs/negate/sign-extend helper used at prep and in FIX.
- Everything else lives in one module.

Test Plan:
- divu: 100 / 7 accepted at T → out_valid only at T+66; quotient=14, remainder=2; div_ready=0 and div_doing=1 during T+1..T+65.
- div signed: -7 / 2 → quotient=0xFFFF_FFFF_FFFF_FFFD (-3), remainder=0xFFFF_FFFF_FFFF_FFFF (-1).
- divuw: dividend=0x0000_0000_FFFF_FFFE, divisor=1 → out_valid at T+34; quotient=0xFFFF_FFFF_FFFF_FFFE (sign-extended), remainder=0.
- Specials:
  - div by zero (5 / 0): quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=5, out_valid at T+1.
  - divw overflow (0x8000_0000 / 0xFFFF_FFFF): quotient=0xFFFF_FFFF_8000_0000, remainder=0.
- div_valid pulsed again during CALC → ignored, result unchanged. Request issued the cycle after out_valid is accepted (back-to-back).
- reset asserted at T+20 of a 64-bit op → next cycle IDLE with all outputs 0 and no out_valid; a following request completes normally.
